life_gen_scheduler: RTL and testbench
=====================================

Name: life_gen_scheduler

Overview:
- Owns the 8x8 Game of Life board and sequences generation updates for the VGA cell renderer.
- Serves the renderer's current and previous 16-bit tile words, selected by its 2-bit tile index, with zero latency.
- Computes the next generation serially, one cell per clock, into a shadow buffer.
- Commits the new generation only on a frame boundary, so every displayed frame shows a single consistent generation.

Parameters:
- FRAMES_PER_GEN, 30, number of frame_start pulses per generation while run=1; legal range 1..255.
- FRAME_CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- run  in  1  level; free-running generation stepping
- single_step  in  1  pulse; request one generation
- clear  in  1  pulse; zero the board
- load_valid  in  1  seed write request
- load_addr  in  6  cell address {X[2:0],Y[2:0]}
- load_data  in  1  cell value
- load_ready  out  1  high when a seed write is accepted
- array_pos  in  2  tile index {X[2],Y[2]} from the renderer
- alive  out  16  current tile word, bit index {X[1:0],Y[1:0]}
- alive_prev  out  16  previous-generation tile word, same indexing
- busy  out  1  high in COMPUTE and COMMIT_WAIT
- generation  out  16  committed generation count

Behaviour:
- Board storage:
  - cur, prev and next are 64-bit flat vectors.
  - Flat index = {X[2],Y[2],X[1:0],Y[1:0]}.
  - alive = cur[array_pos*16 +: 16] and alive_prev = prev[array_pos*16 +: 16], both combinational.
- Reset: cur, prev and next = 0; state = IDLE; frame_cnt = 0; generation = 0. Resulting outputs: busy = 0, load_ready = 1, alive = 0, alive_prev = 0.
- Outputs derived from state: load_ready = (state==IDLE); busy = (state!=IDLE).
- IDLE:
  - run=0: frame_cnt held at 0.
  - run=1 and frame_start with frame_cnt==FRAMES_PER_GEN-1: frame_cnt <= 0, go to COMPUTE.
  - run=1 and frame_start otherwise: frame_cnt++.
  - single_step (any run value): go to COMPUTE.
- COMPUTE:
  - Cell counter i runs 0..63, one cell per cycle.
  - n = count of the 8 neighbours of cell i, read from cur; n is 4 bits, range 0..8.
  - next[i] <= (n==3) | (cur[i] & (n==2)).
  - At i==63, go to COMMIT_WAIT. Exactly 64 cycles.
  - run and single_step are ignored here; a deasserted run does not abort the generation.
- COMMIT_WAIT:
  - On frame_start: prev <= cur; cur <= next; generation <= generation+1, wrapping 0xFFFF->0; go to IDLE.
  - Any frame_start pulses seen in COMPUTE or COMMIT_WAIT are not counted in frame_cnt.
- Seed writes:
  - Accepted when load_valid & load_ready.
  - At that edge, cur[idx] <= load_data and prev[idx] <= load_data, so a seeded cell renders as steady.
- Clear: highest priority in any state. Next cycle: cur, prev and next = 0; generation = 0; frame_cnt = 0; state = IDLE. Any in-flight generation is discarded.
- Simultaneous events:
  - clear + load: the load is dropped.
  - reset dominates everything.
  - load accepted in the same cycle as an IDLE->COMPUTE transition: both take effect; COMPUTE reads the updated cur from its first cycle.
  - single_step and a run-triggered transition in the same cycle: one COMPUTE only.
- Latency: the first cycle of a step request is followed by 64 compute cycles, then up to one frame until commit.

Optional Feature:
- Macro: LIFE_WRAP_EN.
- Defined: the board is toroidal; neighbour coordinates wrap mod 8 on both axes.
- Undefined: cells outside 0..7 count as dead (hard borders).

Decomposition:
- Package life_pkg holds:
  - constants BOARD_DIM=8, BOARD_CELLS=64, TILE_BITS=16;
  - a state enum {IDLE, COMPUTE, COMMIT_WAIT};
  - a function mapping (X,Y) to the flat index.
- Sub-module life_cell_rule is combinational. It takes the 64-bit cur and a 6-bit cell address and produces the next-state bit. The LIFE_WRAP_EN handling lives here.

Test Plan:
- Reset held 2 cycles -> alive=0 and alive_prev=0 for all array_pos; load_ready=1; busy=0; generation=0.
- Seed vertical blinker at (3,2),(3,3),(3,4); single_step -> busy for 64 cycles plus the wait. On frame_start: cells (2,3),(3,3),(4,3) alive in cur; prev holds the vertical pattern; generation=1.
- FRAMES_PER_GEN=2, run=1, blinker seeded, frame_start pulses -> COMPUTE entered after the 2nd pulse; commit on the next pulse; the pattern returns to vertical at generation=2.
- Horizontal blinker at (7,0),(0,0),(1,0), single_step:
  - LIFE_WRAP_EN defined -> cells (0,7),(0,0),(0,1) alive.
  - LIFE_WRAP_EN undefined -> board empty.
- clear asserted mid-COMPUTE (i=20) -> next cycle IDLE, board=0, generation=0; the next frame_start causes no commit.
- load_valid during COMPUTE -> load_ready=0, write dropped, cur unchanged.

Source files
------------

// File: rtl/life_pkg.sv
// Shared constants, FSM state type and board index mapping for the Life generation scheduler.
package life_pkg;

    localparam int BOARD_DIM   = 8;
    localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int TILE_BITS   = 16;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMPUTE     = 2'd1,
        COMMIT_WAIT = 2'd2
    } state_t;

    // Tile-major layout: the renderer's 2-bit tile index selects a 16-bit slice directly.
    function automatic logic [5:0] flat_idx(input logic [2:0] x, input logic [2:0] y);
        return {x[2], y[2], x[1:0], y[1:0]};
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Combinational Game of Life rule for one cell, address {X[2:0],Y[2:0]}.
// LIFE_WRAP_EN selects a toroidal board; otherwise cells beyond the edge count as dead.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [BOARD_CELLS-1:0] cur,
    input  logic [5:0]             cell_addr,
    output logic                   next_bit
);

    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] nx;
    logic [3:0] ny;
    logic [3:0] n;
    logic       in_board;

    assign x = cell_addr[5:3];
    assign y = cell_addr[2:0];

    always_comb begin
        n        = '0;
        nx       = '0;
        ny       = '0;
        in_board = 1'b0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                // 4-bit sums: -1 becomes 15, +1 past the edge becomes 8; bit 3 flags off-board.
                nx = {1'b0, x} + 4'(dx);
                ny = {1'b0, y} + 4'(dy);
`ifdef LIFE_WRAP_EN
                in_board = 1'b1;
`else
                in_board = !nx[3] && !ny[3];
`endif
                if (!(dx == 0 && dy == 0) && in_board) begin
                    n = n + {3'b000, cur[flat_idx(nx[2:0], ny[2:0])]};
                end
            end
        end
        next_bit = (n == 4'd3) | (cur[flat_idx(x, y)] & (n == 4'd2));
    end

endmodule

// File: rtl/life_gen_scheduler.sv
// 8x8 Game of Life board owner: serial next-generation compute, frame-aligned commit, tile read-out.
// Build option LIFE_WRAP_EN (in life_cell_rule) makes the board toroidal.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | board stable, seed writes accepted, counting frames when run=1
// COMPUTE     | one cell per cycle into the shadow buffer, 64 cycles
// COMMIT_WAIT | shadow complete, waiting for frame_start to swap it in
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int FRAMES_PER_GEN = 30,
    parameter int FRAME_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 run,
    input  logic                 single_step,
    input  logic                 clear,
    input  logic                 load_valid,
    input  logic [5:0]           load_addr,
    input  logic                 load_data,
    output logic                 load_ready,
    input  logic [1:0]           array_pos,
    output logic [TILE_BITS-1:0] alive,
    output logic [TILE_BITS-1:0] alive_prev,
    output logic                 busy,
    output logic [15:0]          generation
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAMES_PER_GEN - 1);
    localparam logic [5:0]             CELL_LAST  = 6'(BOARD_CELLS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [BOARD_CELLS-1:0]  cur;
    logic [BOARD_CELLS-1:0]  prev;
    logic [BOARD_CELLS-1:0]  next_gen;
    logic [5:0]              cell_i;
    logic [FRAME_CNT_W-1:0]  frame_cnt;
    logic                    rule_bit;
    logic                    load_fire;
    logic                    run_trigger;
    logic [5:0]              load_idx;

    life_cell_rule u_rule (
        .cur       (cur),
        .cell_addr (cell_i),
        .next_bit  (rule_bit)
    );

    assign load_ready  = (state == IDLE);
    assign busy        = (state != IDLE);
    assign load_fire   = load_valid & load_ready & ~clear;
    assign load_idx    = flat_idx(load_addr[5:3], load_addr[2:0]);
    assign run_trigger = run & frame_start & (frame_cnt == FRAME_LAST);

    assign alive      = cur[{array_pos, 4'b0000} +: TILE_BITS];
    assign alive_prev = prev[{array_pos, 4'b0000} +: TILE_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (single_step || run_trigger) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cell_i == CELL_LAST) begin
                    state_next = COMMIT_WAIT;
                end
            end
            COMMIT_WAIT: begin
                if (frame_start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur        <= '0;
            prev       <= '0;
            next_gen   <= '0;
            cell_i     <= '0;
            frame_cnt  <= '0;
            generation <= '0;
        end else begin
            if (load_fire) begin
                cur[load_idx]  <= load_data;
                prev[load_idx] <= load_data;
            end
            case (state)
                IDLE: begin
                    cell_i <= '0;
                    if (!run) begin
                        frame_cnt <= '0;
                    end else if (frame_start) begin
                        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    next_gen[flat_idx(cell_i[5:3], cell_i[2:0])] <= rule_bit;
                    cell_i <= cell_i + 1'b1;
                end
                COMMIT_WAIT: begin
                    if (frame_start) begin
                        prev       <= cur;
                        cur        <= next_gen;
                        generation <= generation + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Randomized self-checking bench for life_gen_scheduler against a 2-D array Life model.
module tb_life_gen_scheduler;

    localparam int FPG = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        run;
    logic        single_step;
    logic        clear;
    logic        load_valid;
    logic [5:0]  load_addr;
    logic        load_data;
    logic        load_ready;
    logic [1:0]  array_pos;
    logic [15:0] alive;
    logic [15:0] alive_prev;
    logic        busy;
    logic [15:0] generation;

    int checks = 0;
    int errors = 0;

    bit mcur [8][8];
    bit mprev[8][8];
    int mgen;

    life_gen_scheduler #(.FRAMES_PER_GEN(FPG), .FRAME_CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .run         (run),
        .single_step (single_step),
        .clear       (clear),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .array_pos   (array_pos),
        .alive       (alive),
        .alive_prev  (alive_prev),
        .busy        (busy),
        .generation  (generation)
    );

    always #5 clk = ~clk;

    // Tile p covers x in (p/2)*4.., y in (p%2)*4..; bit b covers x offset b/4, y offset b%4.
    function automatic logic [15:0] exp_tile(input int p, input bit use_prev);
        logic [15:0] w;
        int x, y;
        w = '0;
        for (int b = 0; b < 16; b++) begin
            x = (p / 2) * 4 + b / 4;
            y = (p % 2) * 4 + b % 4;
            w[b] = use_prev ? mprev[x][y] : mcur[x][y];
        end
        return w;
    endfunction

    function automatic void model_step();
        bit nb[8][8];
        int n, nx, ny;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                n = 0;
                for (int dx = -1; dx <= 1; dx++) begin
                    for (int dy = -1; dy <= 1; dy++) begin
                        nx = x + dx;
                        ny = y + dy;
`ifdef LIFE_WRAP_EN
                        nx = (nx + 8) % 8;
                        ny = (ny + 8) % 8;
`endif
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
                            n += int'(mcur[nx][ny]);
                    end
                end
                nb[x][y] = (n == 3) || (mcur[x][y] && n == 2);
            end
        end
        mprev = mcur;
        mcur  = nb;
        mgen  = (mgen + 1) % 65536;
    endfunction

    function automatic void model_clear();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                mcur[x][y]  = 1'b0;
                mprev[x][y] = 1'b0;
            end
        mgen = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cell(input int x, input int y, input bit v);
        load_valid = 1'b1;
        load_addr  = 6'(x * 8 + y);
        load_data  = v;
        tick();
        load_valid = 1'b0;
        mcur[x][y]  = v;
        mprev[x][y] = v;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic step_and_commit();
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        repeat (70) tick();
        pulse_fs();
        model_step();
    endtask

    task automatic seed_vertical_blinker();
        load_cell(3, 2, 1'b1);
        load_cell(3, 3, 1'b1);
        load_cell(3, 4, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== 16'h0 || alive_prev !== 16'h0) begin
                errors++;
                $display("FAIL reset_tile%0d: alive=%h prev=%h, want 0", p, alive, alive_prev);
            end
        end
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || generation !== 16'h0) begin
            errors++;
            $display("FAIL reset_status: ready=%b busy=%b gen=%0d, want 1 0 0", load_ready, busy, generation);
        end
    endtask

    task automatic test_single_step();
        int busy_cycles;
        seed_vertical_blinker();
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        frame_start = 1'b1;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            tick();
        end
        frame_start = 1'b0;
        model_step();
        checks++;
        if (busy_cycles != 65) begin
            errors++;
            $display("FAIL step_latency: busy cycles=%0d, want 65", busy_cycles);
        end
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== exp_tile(p, 0) || alive_prev !== exp_tile(p, 1)) begin
                errors++;
                $display("FAIL step_tile%0d: alive=%h prev=%h, want %h %h", p, alive, alive_prev, exp_tile(p, 0), exp_tile(p, 1));
            end
        end
        checks++;
        if (generation !== 16'(mgen) || !mcur[2][3] || !mcur[4][3] || mcur[3][2]) begin
            errors++;
            $display("FAIL step_gen: gen=%0d, want %0d", generation, mgen);
        end
    endtask

    task automatic test_run();
        do_clear();
        seed_vertical_blinker();
        run = 1'b1;
        for (int g = 0; g < 2; g++) begin
            repeat (3) tick();
            pulse_fs();
            repeat (3) tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL run_early_g%0d: busy=%b, want 0", g, busy);
            end
            pulse_fs();
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL run_start_g%0d: busy=%b, want 1", g, busy);
            end
            repeat (20) tick();
            pulse_fs();
            repeat (50) tick();
            checks++;
            if (busy !== 1'b1 || generation !== 16'(mgen)) begin
                errors++;
                $display("FAIL run_hold_g%0d: busy=%b gen=%0d, want 1 %0d", g, busy, generation, mgen);
            end
            pulse_fs();
            model_step();
            for (int p = 0; p < 4; p++) begin
                array_pos = p[1:0];
                #1;
                checks++;
                if (alive !== exp_tile(p, 0) || alive_prev !== exp_tile(p, 1)) begin
                    errors++;
                    $display("FAIL run_tile_g%0d_%0d: alive=%h prev=%h, want %h %h", g, p, alive, alive_prev, exp_tile(p, 0), exp_tile(p, 1));
                end
            end
            checks++;
            if (generation !== 16'(mgen) || busy !== 1'b0) begin
                errors++;
                $display("FAIL run_gen_g%0d: gen=%0d busy=%b, want %0d 0", g, generation, busy, mgen);
            end
        end
        run = 1'b0;
        checks++;
        if (!(mcur[3][2] && mcur[3][3] && mcur[3][4] && !mcur[2][3])) begin
            errors++;
            $display("FAIL run_period2: model pattern not vertical after two steps");
        end
    endtask

    task automatic test_edge_blinker();
        int live;
        do_clear();
        load_cell(7, 0, 1'b1);
        load_cell(0, 0, 1'b1);
        load_cell(1, 0, 1'b1);
        step_and_commit();
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== exp_tile(p, 0)) begin
                errors++;
                $display("FAIL edge_tile%0d: alive=%h, want %h", p, alive, exp_tile(p, 0));
            end
        end
        live = 0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                live += int'(mcur[x][y]);
`ifdef LIFE_WRAP_EN
        checks++;
        if (live != 3 || !mcur[0][7] || !mcur[0][0] || !mcur[0][1]) begin
            errors++;
            $display("FAIL edge_model_wrap: live=%0d, want 3 at (0,7),(0,0),(0,1)", live);
        end
`else
        checks++;
        if (live != 0) begin
            errors++;
            $display("FAIL edge_model_hard: live=%0d, want 0", live);
        end
`endif
    endtask

    task automatic test_random_boards();
        for (int t = 0; t < 4; t++) begin
            do_clear();
            for (int c = 0; c < 64; c++)
                load_cell(c / 8, c % 8, ($urandom_range(0, 99) < 40));
            step_and_commit();
            for (int k = 0; k < 6; k++) begin
                int p;
                p = int'($urandom_range(0, 3));
                array_pos = p[1:0];
                #1;
                checks++;
                if (alive !== exp_tile(p, 0) || alive_prev !== exp_tile(p, 1)) begin
                    errors++;
                    $display("FAIL rand%0d_tile%0d: alive=%h prev=%h, want %h %h", t, p, alive, alive_prev, exp_tile(p, 0), exp_tile(p, 1));
                end
            end
            checks++;
            if (generation !== 16'(mgen)) begin
                errors++;
                $display("FAIL rand%0d_gen: gen=%0d, want %0d", t, generation, mgen);
            end
        end
    endtask

    task automatic test_load_during_compute();
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        repeat (5) tick();
        load_valid = 1'b1;
        load_addr  = 6'(3 * 8 + 5);
        load_data  = ~mcur[3][5];
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_load_ready: ready=%b, want 0", load_ready);
        end
        tick();
        load_valid = 1'b0;
        repeat (70) tick();
        pulse_fs();
        model_step();
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== exp_tile(p, 0) || alive_prev !== exp_tile(p, 1)) begin
                errors++;
                $display("FAIL busy_load_tile%0d: alive=%h prev=%h, want %h %h", p, alive, alive_prev, exp_tile(p, 0), exp_tile(p, 1));
            end
        end
    endtask

    task automatic test_clear_mid_compute();
        checks++;
        if (generation === 16'h0) begin
            errors++;
            $display("FAIL clear_precond: gen=%0d, want nonzero", generation);
        end
        single_step = 1'b1;
        tick();
        single_step = 1'b0;
        repeat (20) tick();
        do_clear();
        checks++;
        if (busy !== 1'b0 || generation !== 16'h0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_status: busy=%b gen=%0d ready=%b, want 0 0 1", busy, generation, load_ready);
        end
        pulse_fs();
        repeat (4) tick();
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== 16'h0 || alive_prev !== 16'h0) begin
                errors++;
                $display("FAIL clear_tile%0d: alive=%h prev=%h, want 0", p, alive, alive_prev);
            end
        end
        checks++;
        if (busy !== 1'b0 || generation !== 16'h0) begin
            errors++;
            $display("FAIL clear_no_commit: busy=%b gen=%0d, want 0 0", busy, generation);
        end
    endtask

    task automatic test_clear_with_load();
        load_valid = 1'b1;
        load_addr  = 6'd9;
        load_data  = 1'b1;
        clear      = 1'b1;
        tick();
        load_valid = 1'b0;
        clear      = 1'b0;
        model_clear();
        for (int p = 0; p < 4; p++) begin
            array_pos = p[1:0];
            #1;
            checks++;
            if (alive !== exp_tile(p, 0)) begin
                errors++;
                $display("FAIL clear_load_tile%0d: alive=%h, want %h", p, alive, exp_tile(p, 0));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        run         = 1'b0;
        single_step = 1'b0;
        clear       = 1'b0;
        load_valid  = 1'b0;
        load_addr   = '0;
        load_data   = 1'b0;
        array_pos   = '0;
        model_clear();
        test_reset();
        test_single_step();
        test_run();
        test_edge_blinker();
        test_random_boards();
        test_load_during_compute();
        test_clear_mid_compute();
        test_clear_with_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
